// File: rtl/seg_pkg.sv
// Purpose: shared constants and hex-to-7-segment decode for the display scanner.
// Contents: SEG_OFF (dark pattern), SEG_TABLE (16 x 7 hex glyphs), seg_decode().
// Segment order is {g,f,e,d,c,b,a}, active-high (raw, before any inversion).
package seg_pkg;

  localparam logic [6:0] SEG_OFF = 7'h00;

  // Entry n holds the glyph for nibble n; listed from F down to 0.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  function automatic logic [6:0] seg_decode(input logic [3:0] nibble);
    return SEG_TABLE[nibble];
  endfunction

endpackage

// File: rtl/milli_prescaler.sv
// Purpose: divides clk down to a one-cycle millisecond pulse using a run-time divisor.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   ticks_per_milli   clk cycles per millisecond; 0 or 1 gives a pulse every cycle
//   milli_tick        registered pulse, high the cycle after count reaches divisor-1
module milli_prescaler #(
  parameter int unsigned TICK_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [TICK_W-1:0] ticks_per_milli,
  output logic              milli_tick
);

  logic [TICK_W-1:0] count_q, count_d;
  logic              tick_q, tick_d;

  // Wrap on >= so a divisor lowered below the running count recovers next cycle.
  always_comb begin
    count_d = count_q + TICK_W'(1);
    tick_d  = 1'b0;
    if ((ticks_per_milli <= TICK_W'(1)) ||
        (count_q >= ticks_per_milli - TICK_W'(1))) begin
      count_d = '0;
      tick_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      tick_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      tick_q  <= tick_d;
    end
  end

  assign milli_tick = tick_q;

endmodule

// File: rtl/seg_scan_driver.sv
// Purpose: multiplexed DIGITS-digit 7-segment scanner with hex decode, leading-zero
// blanking, PWM brightness, frame-coherent value updates and anti-ghosting gaps.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   ticks_per_milli   run-time prescaler divisor (clk cycles per ms)
//   enable            0 = dark, scan parked on digit 0
//   value/load        hex nibbles (digit 0 in [3:0]) and 1-cycle capture strobe
//   blank_lz          blank leading zero digits (never digit 0)
//   brightness        PWM duty, all-ones = always on
//   segments_invert   1 = active-low segment pins
//   segments          {g,f,e,d,c,b,a}, registered
//   digit_sel         one-hot active-high digit enable, registered
//   milli_tick        registered millisecond pulse
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int unsigned DIGITS   = 2,
  parameter int unsigned TICK_W   = 16,
  parameter int unsigned HOLD_MS  = 2,
  parameter int unsigned PWM_BITS = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [TICK_W-1:0]     ticks_per_milli,
  input  logic                  enable,
  input  logic [4*DIGITS-1:0]   value,
  input  logic                  load,
  input  logic                  blank_lz,
  input  logic [PWM_BITS-1:0]   brightness,
  input  logic                  segments_invert,
  output logic [6:0]            segments,
  output logic [DIGITS-1:0]     digit_sel,
  output logic                  milli_tick
);

  localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned MS_W  = (HOLD_MS > 1) ? $clog2(HOLD_MS) : 1;
  localparam int unsigned VAL_W = 4 * DIGITS;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);
  localparam logic [MS_W-1:0]  MS_LAST  = MS_W'(HOLD_MS - 1);

  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [MS_W-1:0]     ms_q, ms_d;
  logic [VAL_W-1:0]    pending_q, pending_d;
  logic [VAL_W-1:0]    display_q, display_d;
  logic [PWM_BITS-1:0] pwm_q, pwm_d;
  logic [6:0]          segments_q, segments_d;
  logic [DIGITS-1:0]   digit_sel_q, digit_sel_d;

  logic       frame_end_c;
  logic [3:0] nibble_c;
  logic       all_zero_c;
  logic       blanked_c;
  logic       lit_c;
  logic [6:0] seg_raw_c;

  milli_prescaler #(.TICK_W(TICK_W)) u_prescaler (
    .clk             (clk),
    .rst_n           (rst_n),
    .ticks_per_milli (ticks_per_milli),
    .milli_tick      (milli_tick)
  );

  // Digit scan: HOLD_MS milliseconds per digit, frame ends when the last digit wraps.
  always_comb begin
    ms_d        = ms_q;
    idx_d       = idx_q;
    frame_end_c = 1'b0;
    if (!enable) begin
      ms_d  = '0;
      idx_d = '0;
    end else if (milli_tick) begin
      if (ms_q == MS_LAST) begin
        ms_d = '0;
        if (idx_q == IDX_LAST) begin
          idx_d       = '0;
          frame_end_c = 1'b1;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end else begin
        ms_d = ms_q + MS_W'(1);
      end
    end
  end

  // Value path: pending takes loads, display only changes between frames (or while dark).
  always_comb begin
    pending_d = load ? value : pending_q;
    display_d = (!enable || frame_end_c) ? pending_q : display_q;
    pwm_d     = pwm_q + PWM_BITS'(1);
  end

  // Current nibble and leading-zero status of the selected digit.
  always_comb begin
    nibble_c   = 4'h0;
    all_zero_c = 1'b1;
    blanked_c  = 1'b0;
    for (int k = 0; k < int'(DIGITS); k++) begin
      if (idx_q == IDX_W'(k)) nibble_c = display_q[4*k +: 4];
    end
    for (int k = int'(DIGITS) - 1; k > 0; k--) begin
      all_zero_c = all_zero_c && (display_q[4*k +: 4] == 4'h0);
      if (idx_q == IDX_W'(k)) blanked_c = all_zero_c;
    end
  end

  // Pin drive: dark while disabled or during the cycle the digit index moves.
  always_comb begin
    lit_c       = (pwm_q < brightness) || (&brightness);
    seg_raw_c   = SEG_OFF;
    digit_sel_d = '0;
    if (enable && (idx_d == idx_q) && lit_c) begin
      digit_sel_d = DIGITS'(1) << idx_q;
      if (!(blank_lz && blanked_c)) seg_raw_c = seg_decode(nibble_c);
    end
    segments_d = seg_raw_c ^ {7{segments_invert}};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q       <= '0;
      ms_q        <= '0;
      pending_q   <= '0;
      display_q   <= '0;
      pwm_q       <= '0;
      segments_q  <= SEG_OFF;
      digit_sel_q <= '0;
    end else begin
      idx_q       <= idx_d;
      ms_q        <= ms_d;
      pending_q   <= pending_d;
      display_q   <= display_d;
      pwm_q       <= pwm_d;
      segments_q  <= segments_d;
      digit_sel_q <= digit_sel_d;
    end
  end

  assign segments  = segments_q;
  assign digit_sel = digit_sel_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Purpose: self-checking bench for seg_scan_driver (DIGITS=2, HOLD_MS=2, PWM_BITS=3).
// Directed scenario tasks check against hand-derived constants; a randomized run is
// checked cycle by cycle against a behavioural display model kept in integers.
module tb_seg_scan_driver;

  localparam int DIGITS   = 2;
  localparam int TICK_W   = 16;
  localparam int HOLD_MS  = 2;
  localparam int PWM_BITS = 3;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [TICK_W-1:0]   ticks_per_milli;
  logic                enable;
  logic [4*DIGITS-1:0] value;
  logic                load;
  logic                blank_lz;
  logic [PWM_BITS-1:0] brightness;
  logic                segments_invert;
  logic [6:0]          segments;
  logic [DIGITS-1:0]   digit_sel;
  logic                milli_tick;

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural model state: values the pins and hidden registers should hold now.
  int m_cnt, m_tick, m_ms, m_idx, m_pwm, m_pend, m_disp, m_seg, m_sel;
  logic [6:0] hex7 [16];

  seg_scan_driver #(
    .DIGITS(DIGITS), .TICK_W(TICK_W), .HOLD_MS(HOLD_MS), .PWM_BITS(PWM_BITS)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .ticks_per_milli (ticks_per_milli),
    .enable          (enable),
    .value           (value),
    .load            (load),
    .blank_lz        (blank_lz),
    .brightness      (brightness),
    .segments_invert (segments_invert),
    .segments        (segments),
    .digit_sel       (digit_sel),
    .milli_tick      (milli_tick)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    m_cnt = 0; m_tick = 0; m_ms = 0; m_idx = 0; m_pwm = 0;
    m_pend = 0; m_disp = 0; m_seg = 0; m_sel = 0;
  endtask

  // Advance the model by one clock using the inputs that will be sampled at the edge.
  task automatic model_step();
    int  t, ntick, ncnt, nms, nidx, nib, bval, full;
    bit  fe, lit, blank;
    t     = int'(ticks_per_milli);
    ntick = (t <= 1 || m_cnt >= t - 1) ? 1 : 0;
    ncnt  = (ntick != 0) ? 0 : m_cnt + 1;
    nms = m_ms; nidx = m_idx; fe = 1'b0;
    if (!enable) begin
      nms = 0; nidx = 0;
    end else if (m_tick != 0) begin
      if (m_ms == HOLD_MS - 1) begin
        nms  = 0;
        nidx = (m_idx + 1) % DIGITS;
        fe   = (m_idx == DIGITS - 1);
      end else begin
        nms = m_ms + 1;
      end
    end
    nib   = (m_disp >> (4 * m_idx)) & 15;
    blank = blank_lz && (m_idx > 0) && ((m_disp >> (4 * m_idx)) == 0);
    full  = (1 << PWM_BITS) - 1;
    bval  = int'(brightness);
    lit   = (m_pwm < bval) || (bval == full);
    m_sel = 0; m_seg = 0;
    if (enable && nidx == m_idx && lit) begin
      m_sel = 1 << m_idx;
      if (!blank) m_seg = int'(hex7[nib]);
    end
    if (segments_invert) m_seg = m_seg ^ 'h7F;
    if (!enable || fe) m_disp = m_pend;
    if (load) m_pend = int'(value);
    m_pwm  = (m_pwm + 1) % (full + 1);
    m_tick = ntick; m_cnt = ncnt; m_ms = nms; m_idx = nidx;
  endtask

  // One clock: model follows the held inputs, outputs then sampled at the next negedge.
  task automatic cycle();
    model_step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_sel(input logic [DIGITS-1:0] want, input int budget, output bit found);
    found = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (digit_sel == want) begin
        found = 1'b1;
        break;
      end
      cycle();
    end
    if (digit_sel == want) found = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_cmp++; if (segments !== 7'h00) begin n_bad++; $display("FAIL reset_segments got=%h exp=00", segments); end
    n_cmp++; if (digit_sel !== 2'b00) begin n_bad++; $display("FAIL reset_digit_sel got=%b exp=00", digit_sel); end
    n_cmp++; if (milli_tick !== 1'b0) begin n_bad++; $display("FAIL reset_milli_tick got=%b exp=0", milli_tick); end
    rst_n = 1'b1;
    cycle();
    n_cmp++; if (segments !== 7'h3F) begin n_bad++; $display("FAIL first_digit_seg got=%h exp=3f", segments); end
    n_cmp++; if (digit_sel !== 2'b01) begin n_bad++; $display("FAIL first_digit_sel got=%b exp=01", digit_sel); end
  endtask

  task automatic test_prescaler();
    int last, gaps, len;
    bit found;
    last = -1; gaps = 0;
    for (int k = 0; k < 200 && gaps < 2; k++) begin
      cycle();
      if (milli_tick) begin
        if (last >= 0) begin
          n_cmp++;
          if (k - last != 50) begin n_bad++; $display("FAIL tick_period got=%0d exp=50", k - last); end
          gaps++;
        end
        last = k;
      end
    end
    n_cmp++; if (gaps < 2) begin n_bad++; $display("FAIL tick_period_timeout got=%0d exp=2 periods", gaps); end
    found = 1'b0;
    for (int k = 0; k < 60; k++) begin
      if (m_cnt == 30) begin found = 1'b1; break; end
      cycle();
    end
    n_cmp++; if (!found) begin n_bad++; $display("FAIL tpm_switch_align got=timeout exp=count 30"); end
    ticks_per_milli = 16'd10;
    cycle();
    n_cmp++; if (milli_tick !== 1'b1) begin n_bad++; $display("FAIL tpm_lowered_tick got=%b exp=1", milli_tick); end
    len = 0;
    for (int k = 1; k <= 30; k++) begin
      cycle();
      if (milli_tick) begin len = k; break; end
    end
    n_cmp++; if (len != 10) begin n_bad++; $display("FAIL tpm10_period got=%0d exp=10", len); end
  endtask

  task automatic test_scan();
    logic [8:0] prev;
    int len;
    bit found;
    ticks_per_milli = 16'd4;
    enable = 1'b0; value = 8'h3A; load = 1'b1;
    cycle();
    load = 1'b0;
    cycle();
    enable = 1'b1; blank_lz = 1'b0; brightness = 3'd7;
    wait_sel(2'b01, 40, found);
    n_cmp++; if (!found) begin n_bad++; $display("FAIL scan_d0_timeout got=%b exp=01", digit_sel); end
    n_cmp++; if (segments !== 7'h77) begin n_bad++; $display("FAIL scan_d0_seg got=%h exp=77", segments); end
    prev = {digit_sel, segments};
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      cycle();
      if (digit_sel == 2'b10) begin found = 1'b1; break; end
      prev = {digit_sel, segments};
    end
    n_cmp++; if (!found) begin n_bad++; $display("FAIL scan_d1_timeout got=%b exp=10", digit_sel); end
    n_cmp++; if (prev !== 9'h000) begin n_bad++; $display("FAIL scan_dark_gap got=%h exp=000", prev); end
    n_cmp++; if (segments !== 7'h4F) begin n_bad++; $display("FAIL scan_d1_seg got=%h exp=4f", segments); end
    len = 0;
    while (digit_sel == 2'b10 && len < 100) begin len++; cycle(); end
    n_cmp++; if (len != HOLD_MS * 4 - 1) begin n_bad++; $display("FAIL scan_hold_len got=%0d exp=%0d", len, HOLD_MS * 4 - 1); end
  endtask

  task automatic test_frame();
    bit found;
    wait_sel(2'b01, 40, found);
    value = 8'h12; load = 1'b1;
    cycle();
    load = 1'b0;
    wait_sel(2'b10, 40, found);
    n_cmp++; if (!found || segments !== 7'h4F) begin n_bad++; $display("FAIL frame_old_d1 got=%b/%h exp=10/4f", digit_sel, segments); end
    wait_sel(2'b01, 40, found);
    n_cmp++; if (!found || segments !== 7'h5B) begin n_bad++; $display("FAIL frame_new_d0 got=%b/%h exp=01/5b", digit_sel, segments); end
    wait_sel(2'b10, 40, found);
    n_cmp++; if (!found || segments !== 7'h06) begin n_bad++; $display("FAIL frame_new_d1 got=%b/%h exp=10/06", digit_sel, segments); end
  endtask

  task automatic test_blank();
    bit found;
    enable = 1'b0; value = 8'h05; load = 1'b1;
    cycle();
    load = 1'b0;
    cycle();
    enable = 1'b1; blank_lz = 1'b1;
    wait_sel(2'b10, 40, found);
    n_cmp++; if (!found || segments !== 7'h00) begin n_bad++; $display("FAIL blank_d1 got=%b/%h exp=10/00", digit_sel, segments); end
    wait_sel(2'b01, 40, found);
    n_cmp++; if (!found || segments !== 7'h6D) begin n_bad++; $display("FAIL blank_d0 got=%b/%h exp=01/6d", digit_sel, segments); end
    enable = 1'b0; value = 8'h00; load = 1'b1;
    cycle();
    load = 1'b0;
    cycle();
    enable = 1'b1;
    wait_sel(2'b01, 40, found);
    n_cmp++; if (!found || segments !== 7'h3F) begin n_bad++; $display("FAIL blank_zero_d0 got=%b/%h exp=01/3f", digit_sel, segments); end
    wait_sel(2'b10, 40, found);
    n_cmp++; if (!found || segments !== 7'h00) begin n_bad++; $display("FAIL blank_zero_d1 got=%b/%h exp=10/00", digit_sel, segments); end
    blank_lz = 1'b0;
  endtask

  task automatic test_pwm();
    int lit;
    logic [PWM_BITS-1:0] levels [3];
    int expect_lit [3];
    levels = '{3'd3, 3'd7, 3'd0};
    expect_lit = '{3, 8, 0};
    ticks_per_milli = 16'd1000;
    enable = 1'b1;
    do_reset();
    for (int j = 0; j < 3; j++) begin
      brightness = levels[j];
      cycle();
      lit = 0;
      for (int i = 0; i < 8; i++) begin
        cycle();
        if (digit_sel != '0) lit++;
      end
      n_cmp++;
      if (lit != expect_lit[j]) begin n_bad++; $display("FAIL pwm_duty_b%0d got=%0d exp=%0d", levels[j], lit, expect_lit[j]); end
    end
    brightness = 3'd7;
  endtask

  task automatic test_invert_and_async_reset();
    segments_invert = 1'b1; enable = 1'b0;
    cycle();
    cycle();
    n_cmp++; if (segments !== 7'h7F) begin n_bad++; $display("FAIL invert_dark_seg got=%h exp=7f", segments); end
    n_cmp++; if (digit_sel !== 2'b00) begin n_bad++; $display("FAIL invert_dark_sel got=%b exp=00", digit_sel); end
    enable = 1'b1; ticks_per_milli = 16'd3; brightness = 3'd7; blank_lz = 1'b0;
    value = 8'h9C; load = 1'b1;
    cycle();
    load = 1'b0;
    for (int i = 0; i < 13; i++) cycle();
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (segments !== 7'h00) begin n_bad++; $display("FAIL async_rst_seg got=%h exp=00", segments); end
    n_cmp++; if (digit_sel !== 2'b00) begin n_bad++; $display("FAIL async_rst_sel got=%b exp=00", digit_sel); end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    cycle();
    n_cmp++; if (segments !== 7'h40) begin n_bad++; $display("FAIL post_rst_seg got=%h exp=40", segments); end
    n_cmp++; if (digit_sel !== 2'b01) begin n_bad++; $display("FAIL post_rst_sel got=%b exp=01", digit_sel); end
    segments_invert = 1'b0;
  endtask

  task automatic test_random();
    ticks_per_milli = 16'd3;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 49) == 0) ticks_per_milli = TICK_W'($urandom_range(0, 6));
      if ($urandom_range(0, 29) == 0) brightness = PWM_BITS'($urandom_range(0, 7));
      if ($urandom_range(0, 99) == 0) blank_lz = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 199) == 0) segments_invert = 1'($urandom_range(0, 1));
      enable = ($urandom_range(0, 39) != 0);
      load   = ($urandom_range(0, 9) == 0);
      value  = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 3) == 0) value[7:4] = 4'h0;
      cycle();
      n_cmp++; if (segments !== 7'(m_seg)) begin n_bad++; $display("FAIL rand_seg cyc=%0d got=%h exp=%h", i, segments, 7'(m_seg)); end
      n_cmp++; if (digit_sel !== 2'(m_sel)) begin n_bad++; $display("FAIL rand_sel cyc=%0d got=%b exp=%b", i, digit_sel, 2'(m_sel)); end
      n_cmp++; if (milli_tick !== 1'(m_tick)) begin n_bad++; $display("FAIL rand_tick cyc=%0d got=%b exp=%b", i, milli_tick, 1'(m_tick)); end
    end
  endtask

  initial begin
    hex7 = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    ticks_per_milli = 16'd50;
    enable = 1'b1; value = '0; load = 1'b0; blank_lz = 1'b0;
    brightness = 3'd7; segments_invert = 1'b0;
    model_reset();
    test_reset();
    test_prescaler();
    test_scan();
    test_frame();
    test_blank();
    test_pwm();
    test_invert_and_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
